tumbler_draw_sequencer: RTL and testbench

TUMBLER_DRAW_SEQUENCER -- requirements
Module: tumbler_draw_sequencer

---
 rtl/tumbler_draw_sequencer_pkg.sv | 23 ++
 rtl/tumbler_draw_sequencer_seq_delay_counter.sv | 34 +++
 rtl/tumbler_draw_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_tumbler_draw_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tumbler_draw_sequencer_pkg.sv
// rtl/tumbler_draw_sequencer_pkg.sv - shared state encoding, colours and sizing helper
`timescale 1ns/1ps
package tumbler_draw_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PRESS  = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    localparam logic [2:0] COL_SOLVED = 3'b010;
    localparam logic [2:0] COL_SEL    = 3'b110;
    localparam logic [2:0] COL_NORM   = 3'b111;

    // Wide enough to hold the larger of the two delays without wrapping.
    function automatic int cnt_width(input int press, input int settle);
        int m;
        m = (press > settle) ? press : settle;
        return ($clog2(m + 1) > 1) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/tumbler_draw_sequencer_seq_delay_counter.sv
// rtl/tumbler_draw_sequencer_seq_delay_counter.sv - loadable count-down timer with zero flag
`timescale 1ns/1ps
module seq_delay_counter #(
    parameter int WIDTH = 11
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tumbler_draw_sequencer.sv
// rtl/tumbler_draw_sequencer.sv - sequences one square draw per tumbler through the draw stage
`timescale 1ns/1ps
module tumbler_draw_sequencer
    import tumbler_draw_sequencer_pkg::*;
#(
    parameter int NUM_T      = 4,
    parameter int X_BASE     = 40,
    parameter int X_PITCH    = 16,
    parameter int Y_BASE     = 40,
    parameter int Y_STEP     = 4,
    parameter int PRESS_CYC  = 4,
    parameter int SETTLE_CYC = 1100
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               update,
    input  logic [3*NUM_T-1:0] heights,
    input  logic [NUM_T-1:0]   pinned,
    input  logic [1:0]         sel,
    input  logic               solved,
    output logic [7:0]         x_out,
    output logic [7:0]         y_out,
    output logic [2:0]         colour_out,
    output logic               draw_n,
    output logic               draw_full,
    output logic               busy,
    output logic               frame_done
);

    localparam int CW = cnt_width(PRESS_CYC, SETTLE_CYC);
    localparam int IW = (NUM_T > 1) ? $clog2(NUM_T) : 1;

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               pending_q, pending_d;
    logic [3*NUM_T-1:0] heights_s_q, heights_s_d;
    logic [NUM_T-1:0]   pinned_s_q, pinned_s_d;
    logic [1:0]         sel_s_q, sel_s_d;
    logic               solved_s_q, solved_s_d;
    logic [7:0]         x_q, x_d, y_q, y_d;
    logic [2:0]         colour_q, colour_d;
    logic               draw_full_q, draw_full_d;
    logic               draw_n_q, draw_n_d;
    logic               frame_done_q, frame_done_d;

    logic               cnt_load;
    logic [CW-1:0]      cnt_val;
    logic               cnt_zero;
    logic               snap;
    logic [2:0]         hgt;

    seq_delay_counter #(.WIDTH(CW)) u_delay (
        .clock    (clock),
        .resetn   (resetn),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        heights_s_d  = heights_s_q;
        pinned_s_d   = pinned_s_q;
        sel_s_d      = sel_s_q;
        solved_s_d   = solved_s_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        draw_full_d  = draw_full_q;
        draw_n_d     = draw_n_q;
        frame_done_d = 1'b0;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        snap         = 1'b0;
        hgt          = heights_s_q[3*int'(idx_q) +: 3];

        // Any request while a frame is running collapses into one pending redraw.
        if (update && state_q != ST_IDLE) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (update) begin
                    snap    = 1'b1;
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                x_d = 8'(X_BASE + int'(idx_q) * X_PITCH);
                y_d = 8'(Y_BASE + (7 - int'(hgt)) * Y_STEP);
                if (solved_s_q) begin
                    colour_d = COL_SOLVED;
                end else if (int'(idx_q) == int'(sel_s_q)) begin
                    colour_d = COL_SEL;
                end else begin
                    colour_d = COL_NORM;
                end
                draw_full_d = pinned_s_q[idx_q];
                cnt_load    = 1'b1;
                cnt_val     = CW'(PRESS_CYC - 1);
                draw_n_d    = 1'b0;
                state_d     = ST_PRESS;
            end
            ST_PRESS: begin
                if (cnt_zero) begin
                    draw_n_d = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(SETTLE_CYC - 1);
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    if (int'(idx_q) < NUM_T - 1) begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_LOAD;
                    end else begin
                        frame_done_d = 1'b1;
                        // A request landing on the final cycle counts as pending too.
                        if (pending_q || update) begin
                            pending_d = 1'b0;
                            snap      = 1'b1;
                            idx_d     = '0;
                            state_d   = ST_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (snap) begin
            heights_s_d = heights;
            pinned_s_d  = pinned;
            sel_s_d     = sel;
            solved_s_d  = solved;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            heights_s_q  <= '0;
            pinned_s_q   <= '0;
            sel_s_q      <= '0;
            solved_s_q   <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            draw_full_q  <= 1'b0;
            draw_n_q     <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            heights_s_q  <= heights_s_d;
            pinned_s_q   <= pinned_s_d;
            sel_s_q      <= sel_s_d;
            solved_s_q   <= solved_s_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            draw_full_q  <= draw_full_d;
            draw_n_q     <= draw_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign x_out      = x_q;
    assign y_out      = y_q;
    assign colour_out = colour_q;
    assign draw_full  = draw_full_q;
    assign draw_n     = draw_n_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tumbler_draw_sequencer.sv
// tb/tb_tumbler_draw_sequencer.sv - self-checking bench for tumbler_draw_sequencer
`timescale 1ns/1ps
module tb_tumbler_draw_sequencer;

    localparam int NUM_T      = 4;
    localparam int PRESS_CYC  = 4;
    localparam int SETTLE_CYC = 1100;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        update = 1'b0;
    logic [11:0] heights = '0;
    logic [3:0]  pinned = '0;
    logic [1:0]  sel = '0;
    logic        solved = 1'b0;
    logic [7:0]  x_out, y_out;
    logic [2:0]  colour_out;
    logic        draw_n, draw_full, busy, frame_done;

    always #10 clock = ~clock;

    tumbler_draw_sequencer #(
        .NUM_T(NUM_T), .X_BASE(40), .X_PITCH(16), .Y_BASE(40), .Y_STEP(4),
        .PRESS_CYC(PRESS_CYC), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clock(clock), .resetn(resetn), .update(update), .heights(heights),
        .pinned(pinned), .sel(sel), .solved(solved), .x_out(x_out), .y_out(y_out),
        .colour_out(colour_out), .draw_n(draw_n), .draw_full(draw_full),
        .busy(busy), .frame_done(frame_done)
    );

    typedef struct {
        int x; int y; int c; int f; int low; int high; bit stable;
    } draw_t;

    int     passes = 0;
    int     total  = 0;
    int     fd_cnt = 0;
    int     fall_cnt = 0;
    bit     fd_busy_q[$];
    draw_t  draws_q[$];
    draw_t  cur;
    bit     active = 0;
    logic   prev_dn = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Observe the draw-stage handshake: one record per square drawn.
    always @(negedge clock) begin
        if (!resetn) begin
            active  = 0;
            prev_dn = 1'b1;
        end else begin
            if (frame_done) begin
                fd_cnt++;
                fd_busy_q.push_back(busy);
                if (active) begin
                    draws_q.push_back(cur);
                    active = 0;
                end
            end
            if (draw_n == 1'b0 && prev_dn == 1'b1) begin
                if (active) draws_q.push_back(cur);
                cur.x = int'(x_out); cur.y = int'(y_out);
                cur.c = int'(colour_out); cur.f = int'(draw_full);
                cur.low = 1; cur.high = 0; cur.stable = 1;
                active = 1;
                fall_cnt++;
            end else if (active) begin
                if (int'(x_out) != cur.x || int'(y_out) != cur.y ||
                    int'(colour_out) != cur.c || int'(draw_full) != cur.f)
                    cur.stable = 0;
                if (draw_n == 1'b0) cur.low++;
                else cur.high++;
            end
            prev_dn = draw_n;
        end
    end

    task automatic pulse_update();
        @(negedge clock);
        update = 1'b1;
        @(negedge clock);
        update = 1'b0;
    endtask

    task automatic wait_fd(input int target, input int budget);
        for (int i = 0; i < budget && fd_cnt < target; i++) @(negedge clock);
        chk("frame_done_reached", 32'(fd_cnt >= target), 32'd1);
    endtask

    task automatic check_frame(input string nm, input logic [11:0] h, input logic [3:0] p,
                               input logic [1:0] s, input logic sv);
        draw_t r;
        int hi;
        for (int i = 0; i < NUM_T; i++) begin
            chk($sformatf("%s_d%0d_present", nm, i), 32'(draws_q.size() > 0), 32'd1);
            if (draws_q.size() == 0) return;
            r  = draws_q.pop_front();
            hi = int'((h >> (3 * i)) & 12'h7);
            chk($sformatf("%s_d%0d_x", nm, i), r.x, (40 + 16 * i) % 256);
            chk($sformatf("%s_d%0d_y", nm, i), r.y, (40 + (7 - hi) * 4) % 256);
            chk($sformatf("%s_d%0d_colour", nm, i), r.c, sv ? 2 : ((i == int'(s)) ? 6 : 7));
            chk($sformatf("%s_d%0d_full", nm, i), r.f, int'(p[i]));
            chk($sformatf("%s_d%0d_low", nm, i), r.low, PRESS_CYC);
            chk($sformatf("%s_d%0d_high", nm, i), r.high,
                (i == NUM_T - 1) ? SETTLE_CYC : SETTLE_CYC + 1);
            chk($sformatf("%s_d%0d_stable", nm, i), 32'(r.stable), 32'd1);
        end
    endtask

    logic [11:0] ha, hb;
    logic [3:0]  pa, pb;
    logic [1:0]  sa, sb;
    logic        va, vb;
    int          base, fc;

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        #1;
        chk("rst_draw_n", 32'(draw_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_x", 32'(x_out), 32'd0);
        chk("rst_y", 32'(y_out), 32'd0);
        chk("rst_colour", 32'(colour_out), 32'd0);
        chk("rst_full", 32'(draw_full), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // All heights zero, tumbler 1 selected
        heights = 12'h000; pinned = 4'b0000; sel = 2'd1; solved = 1'b0;
        base = fd_cnt; fd_busy_q.delete();
        pulse_update();
        chk("busy_after_update", 32'(busy), 32'd1);
        wait_fd(base + 1, 6000);
        check_frame("basic", 12'h000, 4'b0000, 2'd1, 1'b0);
        repeat (5) @(negedge clock);
        chk("basic_one_frame", fd_cnt, base + 1);
        chk("basic_idle_busy", 32'(busy), 32'd0);
        chk("basic_fd_busy", 32'(fd_busy_q.pop_front()), 32'd0);

        // Solved lock with alternate pinned tumblers
        ha = 12'($urandom); sa = 2'($urandom);
        heights = ha; pinned = 4'b0101; sel = sa; solved = 1'b1;
        base = fd_cnt;
        pulse_update();
        wait_fd(base + 1, 6000);
        check_frame("solved", ha, 4'b0101, sa, 1'b1);

        // Three updates mid-frame collapse into one extra frame
        ha = 12'($urandom); pa = 4'($urandom); sa = 2'($urandom); va = 1'b0;
        hb = 12'($urandom); pb = 4'($urandom); sb = 2'($urandom); vb = 1'($urandom);
        heights = ha; pinned = pa; sel = sa; solved = va;
        base = fd_cnt; fd_busy_q.delete();
        pulse_update();
        repeat (300) @(negedge clock);
        pulse_update();
        heights = hb; pinned = pb; sel = sb; solved = vb;
        repeat (700) @(negedge clock);
        pulse_update();
        repeat (800) @(negedge clock);
        pulse_update();
        wait_fd(base + 2, 12000);
        check_frame("pend_a", ha, pa, sa, va);
        check_frame("pend_b", hb, pb, sb, vb);
        repeat (50) @(negedge clock);
        chk("pend_two_frames", fd_cnt, base + 2);
        chk("pend_idle_busy", 32'(busy), 32'd0);
        chk("pend_restart_busy", 32'(fd_busy_q.pop_front()), 32'd1);
        chk("pend_end_busy", 32'(fd_busy_q.pop_front()), 32'd0);

        // Update on the final settle cycle of a frame
        ha = 12'($urandom); pa = 4'($urandom); sa = 2'($urandom); va = 1'b0;
        hb = 12'($urandom); pb = 4'($urandom); sb = 2'($urandom); vb = 1'b0;
        heights = ha; pinned = pa; sel = sa; solved = va;
        base = fd_cnt; fd_busy_q.delete();
        pulse_update();
        repeat (2000) @(negedge clock);
        heights = hb; pinned = pb; sel = sb; solved = vb;
        repeat (2419) @(negedge clock);
        update = 1'b1;
        @(negedge clock);
        update = 1'b0;
        wait_fd(base + 2, 12000);
        check_frame("coin_a", ha, pa, sa, va);
        check_frame("coin_b", hb, pb, sb, vb);
        repeat (50) @(negedge clock);
        chk("coin_two_frames", fd_cnt, base + 2);
        chk("coin_restart_busy", 32'(fd_busy_q.pop_front()), 32'd1);

        // Random frames with inputs scrambled after the snapshot
        for (int k = 0; k < 2; k++) begin
            ha = 12'($urandom); pa = 4'($urandom); sa = 2'($urandom); va = 1'($urandom);
            heights = ha; pinned = pa; sel = sa; solved = va;
            base = fd_cnt;
            pulse_update();
            repeat (2000) begin
                @(negedge clock);
                heights = 12'($urandom); pinned = 4'($urandom);
                sel = 2'($urandom); solved = 1'($urandom);
            end
            wait_fd(base + 1, 6000);
            check_frame($sformatf("rand%0d", k), ha, pa, sa, va);
        end

        // Reset while tumbler 2 is being pressed
        heights = 12'h123; pinned = 4'b0011; sel = 2'd2; solved = 1'b0;
        draws_q.delete();
        fc = fall_cnt;
        pulse_update();
        for (int i = 0; i < 6000 && fall_cnt < fc + 3; i++) @(negedge clock);
        chk("rst_press_reached", 32'(fall_cnt >= fc + 3), 32'd1);
        #2;
        chk("rst_press_low_before", 32'(draw_n), 32'd0);
        resetn = 1'b0;
        #1;
        chk("rst_press_draw_n", 32'(draw_n), 32'd1);
        chk("rst_press_busy", 32'(busy), 32'd0);
        chk("rst_press_x", 32'(x_out), 32'd0);
        chk("rst_press_colour", 32'(colour_out), 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        fc = fall_cnt; base = fd_cnt;
        repeat (3000) @(negedge clock);
        chk("rst_press_no_draws", fall_cnt, fc);
        chk("rst_press_no_frame", fd_cnt, base);
        chk("rst_press_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
